// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock qualifier.
// Pulses the PLL reset, waits for lock with a timeout/retry loop, requires a
// stable lock window before releasing the system reset, and re-sequences on
// lock loss or on a soft re-lock request. Runs entirely on the board clock.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             inclk0,
  input  logic             areset,
  input  logic             pll_locked,
  input  logic             soft_relock,
  output logic             pll_areset,
  output logic             sys_rst,
  output logic             sys_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  // One shared cycle counter must reach the largest terminal count.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic [CYC_W-1:0] cyc;
  logic             lock_meta;
  logic             locked_s;
  logic             timeout_evt;
  logic             loss_evt;

  // Event counters stick at all-ones so a long-running system never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign state = cur;

  // Next-state decision; lock loss always outranks a soft re-lock request.
  always_comb begin
    nxt         = cur;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (cur)
      RESET_PLL: begin
        if (cyc == RST_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          nxt = STABLE;
        end else if (cyc == TIMEOUT_LAST) begin
          nxt         = RESET_PLL;
          timeout_evt = 1'b1;
        end else if (soft_relock) begin
          nxt = RESET_PLL;
        end
      end
      STABLE: begin
        // A lock glitch restarts the whole lock wait rather than retrying the PLL.
        if (!locked_s)                nxt = WAIT_LOCK;
        else if (soft_relock)         nxt = RESET_PLL;
        else if (cyc == STABLE_LAST)  nxt = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          nxt      = RESET_PLL;
          loss_evt = 1'b1;
        end else if (soft_relock) begin
          nxt = RESET_PLL;
        end
      end
      default: nxt = RESET_PLL;
    endcase
  end

  // State, lock synchronizer, cycle counter, event counters and outputs registered from next state.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      cur         <= RESET_PLL;
      cyc         <= '0;
      lock_meta   <= 1'b0;
      locked_s    <= 1'b0;
      pll_areset  <= 1'b1;
      sys_rst     <= 1'b1;
      sys_ready   <= 1'b0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      lock_meta  <= pll_locked;
      locked_s   <= lock_meta;
      cur        <= nxt;
      cyc        <= (nxt != cur) ? '0 : cyc + 1'b1;
      pll_areset <= (nxt == RESET_PLL);
      sys_rst    <= (nxt != RUN);
      sys_ready  <= (nxt == RUN);
      if (loss_evt)    relock_cnt  <= sat_inc(relock_cnt);
      if (timeout_evt) timeout_cnt <= sat_inc(timeout_cnt);
    end
  end

endmodule
